// File: rtl/sap1_control_if.sv
// sap1_control_if: control bundle between the SAP-1 sequencer and its datapath.
//
// WIDTH : instruction register width. The opcode is the top four bits.
//
// Signal groups
//   step/inputs  : mclk_en, i_instr, i_zero, i_carry, i_odd
//   sequencer    : o_tstate, o_hlt
//   PC strobes   : o_pc_out, o_pc_inc, o_pc_load
//   memory / IR  : o_mar_in, o_ram_in, o_ram_out, o_ir_in, o_ir_out
//   A / B / OUT  : o_a_in, o_a_out, o_b_in, o_out_in
//   ALU          : o_alu_out, o_alu_sub, o_alu_latch_flags
//
// Modports
//   master : the sequencer. It samples the step enable, IR and flags and
//            drives every strobe.
//   slave  : the datapath side. It drives the step enable, IR and flags and
//            observes the strobes.
//
// Handshake: there is no valid/ready pair. mclk_en qualifies each rising edge,
// and the sequencer advances exactly one microstep on every qualified edge.
// Halt is the only exception: once halted, only reset moves the sequencer.
// Every strobe is a level for the current microstep, and the datapath acts on
// it at the next qualified edge.
interface sap1_control_if #(
  parameter int WIDTH = 8
);
  logic             mclk_en;
  logic [WIDTH-1:0] i_instr;
  logic             i_zero;
  logic             i_carry;
  logic             i_odd;

  logic [2:0]       o_tstate;
  logic             o_hlt;
  logic             o_pc_out;
  logic             o_pc_inc;
  logic             o_pc_load;
  logic             o_mar_in;
  logic             o_ram_in;
  logic             o_ram_out;
  logic             o_ir_in;
  logic             o_ir_out;
  logic             o_a_in;
  logic             o_a_out;
  logic             o_b_in;
  logic             o_out_in;
  logic             o_alu_out;
  logic             o_alu_sub;
  logic             o_alu_latch_flags;

  modport master (
    input  mclk_en, i_instr, i_zero, i_carry, i_odd,
    output o_tstate, o_hlt, o_pc_out, o_pc_inc, o_pc_load,
           o_mar_in, o_ram_in, o_ram_out, o_ir_in, o_ir_out,
           o_a_in, o_a_out, o_b_in, o_out_in,
           o_alu_out, o_alu_sub, o_alu_latch_flags
  );

  modport slave (
    output mclk_en, i_instr, i_zero, i_carry, i_odd,
    input  o_tstate, o_hlt, o_pc_out, o_pc_inc, o_pc_load,
           o_mar_in, o_ram_in, o_ram_out, o_ir_in, o_ir_out,
           o_a_in, o_a_out, o_b_in, o_out_in,
           o_alu_out, o_alu_sub, o_alu_latch_flags
  );
endinterface

// File: rtl/sap1_control.sv
// sap1_control: SAP-1 instruction sequencer.
//
// This module keeps the microstep (T-state) counter and decodes the opcode
// held in the IR. From the current step, the opcode and the latched ALU flags
// it drives every datapath strobe. Instructions take 3, 4 or 5 steps. HLT
// parks the sequencer until reset.
//
// Ports
//   mclk  : master clock. All state changes happen on the rising edge.
//   i_rst : synchronous, active-high reset. It overrides mclk_en and halt.
//   bus   : sap1_control_if.master. It carries the step enable, the IR, the
//           flags, o_tstate (the state debug view), o_hlt and all strobes.
//
// Build option
//   SAP1_COND_JUMP_EN : when defined, JC/JZ/JO (opcodes 7/8/9) load the PC
//                       if their flag is set. When undefined, those opcodes
//                       run as NOP and the flag inputs are ignored.
module sap1_control #(
  parameter int WIDTH = 8
) (
  input  logic            mclk,
  input  logic            i_rst,
  sap1_control_if.master  bus
);

  // HALT is a separate state so that the hold does not depend on the IR
  // staying unchanged. It reports itself as T2 on o_tstate.
  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    HALT = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_JO  = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state_q, state_d;
  logic [3:0] opcode;
  logic       is_cond_jump;
  logic       jump_taken;

  logic hlt, pc_out, pc_inc, pc_load, mar_in, ram_in, ram_out, ir_in, ir_out;
  logic a_in, a_out, b_in, out_in, alu_out, alu_sub, alu_latch_flags;

  assign opcode = bus.i_instr[WIDTH-1 -: 4];

  // The operand field belongs to the datapath; only the opcode is decoded here.
  logic instr_unused;
  assign instr_unused = ^bus.i_instr;

`ifdef SAP1_COND_JUMP_EN
  assign is_cond_jump = (opcode == OP_JC) || (opcode == OP_JZ) || (opcode == OP_JO);
  assign jump_taken   = ((opcode == OP_JC) && bus.i_carry) ||
                        ((opcode == OP_JZ) && bus.i_zero)  ||
                        ((opcode == OP_JO) && bus.i_odd);
`else
  logic flags_unused;
  assign flags_unused = bus.i_zero ^ bus.i_carry ^ bus.i_odd;
  assign is_cond_jump = 1'b0;
  assign jump_taken   = 1'b0;
`endif

  always_ff @(posedge mclk) begin
    if (i_rst) state_q <= T0;
    else       state_q <= state_d;
  end

  // Next microstep. HALT ignores mclk_en; every other state waits for it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      T0: if (bus.mclk_en) state_d = T1;
      T1: if (bus.mclk_en) state_d = T2;
      T2: begin
        if (bus.mclk_en) begin
          if (opcode == OP_HLT) state_d = HALT;
          else if ((opcode == OP_LDA) || (opcode == OP_ADD) ||
                   (opcode == OP_SUB) || (opcode == OP_STA)) state_d = T3;
          else state_d = T0;
        end
      end
      // Only ADD and SUB use the fifth step.
      T3: begin
        if (bus.mclk_en) begin
          if ((opcode == OP_ADD) || (opcode == OP_SUB)) state_d = T4;
          else state_d = T0;
        end
      end
      T4:      if (bus.mclk_en) state_d = T0;
      HALT:    state_d = HALT;
      default: state_d = T0;
    endcase
  end

  // Strobe decode. Every strobe defaults to 0 and is set only in its step.
  always_comb begin
    hlt = 1'b0; pc_out = 1'b0; pc_inc = 1'b0; pc_load = 1'b0;
    mar_in = 1'b0; ram_in = 1'b0; ram_out = 1'b0; ir_in = 1'b0; ir_out = 1'b0;
    a_in = 1'b0; a_out = 1'b0; b_in = 1'b0; out_in = 1'b0;
    alu_out = 1'b0; alu_sub = 1'b0; alu_latch_flags = 1'b0;
    case (state_q)
      T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
      end
      T1: begin
        ram_out = 1'b1;
        ir_in   = 1'b1;
        pc_inc  = 1'b1;
      end
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ir_out = 1'b1;
            mar_in = 1'b1;
          end
          OP_LDI: begin
            ir_out = 1'b1;
            a_in   = 1'b1;
          end
          OP_JMP: begin
            ir_out  = 1'b1;
            pc_load = 1'b1;
          end
          OP_OUT: begin
            a_out  = 1'b1;
            out_in = 1'b1;
          end
          OP_HLT: hlt = 1'b1;
          default: begin
            // Conditional jumps put the target on the bus even when not taken.
            ir_out  = is_cond_jump;
            pc_load = jump_taken;
          end
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: begin
            ram_out = 1'b1;
            a_in    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ram_out = 1'b1;
            b_in    = 1'b1;
          end
          OP_STA: begin
            a_out  = 1'b1;
            ram_in = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
          alu_out         = 1'b1;
          a_in            = 1'b1;
          alu_latch_flags = 1'b1;
          alu_sub         = (opcode == OP_SUB);
        end
      end
      HALT:    hlt = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_tstate          = (state_q == HALT) ? 3'd2 : state_q;
  assign bus.o_hlt             = hlt;
  assign bus.o_pc_out          = pc_out;
  assign bus.o_pc_inc          = pc_inc;
  assign bus.o_pc_load         = pc_load;
  assign bus.o_mar_in          = mar_in;
  assign bus.o_ram_in          = ram_in;
  assign bus.o_ram_out         = ram_out;
  assign bus.o_ir_in           = ir_in;
  assign bus.o_ir_out          = ir_out;
  assign bus.o_a_in            = a_in;
  assign bus.o_a_out           = a_out;
  assign bus.o_b_in            = b_in;
  assign bus.o_out_in          = out_in;
  assign bus.o_alu_out         = alu_out;
  assign bus.o_alu_sub         = alu_sub;
  assign bus.o_alu_latch_flags = alu_latch_flags;

endmodule

// File: tb/tb_sap1_control.sv
// tb_sap1_control: bench for sap1_control.
//
// A step-count model tracks the position inside the current instruction and
// the halt condition. Expected strobes come from a per-opcode table of
// microsteps. Directed sequences pin the model with literal values, and a
// random phase then exercises enable patterns, opcodes, flags and resets.
module tb_sap1_control;

  logic mclk = 1'b0;
  logic i_rst;
  always #5 mclk = ~mclk;

  sap1_control_if #(.WIDTH(8)) bus ();

  sap1_control #(.WIDTH(8)) dut (
    .mclk  (mclk),
    .i_rst (i_rst),
    .bus   (bus)
  );

`ifdef SAP1_COND_JUMP_EN
  localparam bit COND = 1'b1;
`else
  localparam bit COND = 1'b0;
`endif

  // Bit positions of the strobe vector.
  localparam int B_HLT = 0,  B_PC_OUT = 1,  B_PC_INC = 2,  B_PC_LOAD = 3;
  localparam int B_MAR_IN = 4, B_RAM_IN = 5, B_RAM_OUT = 6, B_IR_IN = 7;
  localparam int B_IR_OUT = 8, B_A_IN = 9, B_A_OUT = 10, B_B_IN = 11;
  localparam int B_OUT_IN = 12, B_ALU_OUT = 13, B_ALU_SUB = 14, B_LATCH = 15;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [15:0] act;
  always_comb begin
    act = '0;
    act[B_HLT]     = bus.o_hlt;
    act[B_PC_OUT]  = bus.o_pc_out;
    act[B_PC_INC]  = bus.o_pc_inc;
    act[B_PC_LOAD] = bus.o_pc_load;
    act[B_MAR_IN]  = bus.o_mar_in;
    act[B_RAM_IN]  = bus.o_ram_in;
    act[B_RAM_OUT] = bus.o_ram_out;
    act[B_IR_IN]   = bus.o_ir_in;
    act[B_IR_OUT]  = bus.o_ir_out;
    act[B_A_IN]    = bus.o_a_in;
    act[B_A_OUT]   = bus.o_a_out;
    act[B_B_IN]    = bus.o_b_in;
    act[B_OUT_IN]  = bus.o_out_in;
    act[B_ALU_OUT] = bus.o_alu_out;
    act[B_ALU_SUB] = bus.o_alu_sub;
    act[B_LATCH]   = bus.o_alu_latch_flags;
  end

  task automatic chk(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_t    = 0;   // steps taken inside the current instruction
  bit m_halt = 1'b0;

  function automatic int instr_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  always @(posedge mclk) begin
    if (i_rst) begin
      m_t = 0; m_halt = 1'b0;
    end else if (!m_halt && bus.mclk_en) begin
      if (m_t == 2 && bus.i_instr[7:4] == 4'hF) m_halt = 1'b1;
      else if (m_t + 1 >= instr_len(bus.i_instr[7:4])) m_t = 0;
      else m_t = m_t + 1;
    end
  end

  function automatic logic [15:0] exp_ctrl(input int t, input bit h, input logic [3:0] op,
                                           input bit z, input bit c, input bit o);
    logic [15:0] e;
    bit flag;
    e = '0;
    if (h) begin
      e[B_HLT] = 1'b1;
      return e;
    end
    flag = (op == 4'h7) ? c : (op == 4'h8) ? z : o;
    if (t == 0) begin
      e[B_PC_OUT] = 1'b1; e[B_MAR_IN] = 1'b1;
    end else if (t == 1) begin
      e[B_RAM_OUT] = 1'b1; e[B_IR_IN] = 1'b1; e[B_PC_INC] = 1'b1;
    end else if (t == 2) begin
      if (op >= 4'h1 && op <= 4'h4) begin e[B_IR_OUT] = 1'b1; e[B_MAR_IN] = 1'b1; end
      else if (op == 4'h5) begin e[B_IR_OUT] = 1'b1; e[B_A_IN] = 1'b1; end
      else if (op == 4'h6) begin e[B_IR_OUT] = 1'b1; e[B_PC_LOAD] = 1'b1; end
      else if (op >= 4'h7 && op <= 4'h9 && COND) begin
        e[B_IR_OUT] = 1'b1; e[B_PC_LOAD] = flag;
      end
      else if (op == 4'hE) begin e[B_A_OUT] = 1'b1; e[B_OUT_IN] = 1'b1; end
      else if (op == 4'hF) e[B_HLT] = 1'b1;
    end else if (t == 3) begin
      if (op == 4'h1) begin e[B_RAM_OUT] = 1'b1; e[B_A_IN] = 1'b1; end
      else if (op == 4'h2 || op == 4'h3) begin e[B_RAM_OUT] = 1'b1; e[B_B_IN] = 1'b1; end
      else if (op == 4'h4) begin e[B_A_OUT] = 1'b1; e[B_RAM_IN] = 1'b1; end
    end else if (t == 4) begin
      if (op == 4'h2 || op == 4'h3) begin
        e[B_ALU_OUT] = 1'b1; e[B_A_IN] = 1'b1; e[B_LATCH] = 1'b1;
        e[B_ALU_SUB] = (op == 4'h3);
      end
    end
    return e;
  endfunction

  // Every-cycle compare against the model, plus the single-bus-driver rule.
  always @(negedge mclk) begin
    if (chk_en) begin
      chk("tstate", int'(bus.o_tstate), m_halt ? 2 : m_t);
      chk("ctrl", int'(act), int'(exp_ctrl(m_t, m_halt, bus.i_instr[7:4],
                                           bus.i_zero, bus.i_carry, bus.i_odd)));
      chk("bus_drivers", ($countones({bus.o_pc_out, bus.o_ram_out, bus.o_ir_out,
                                      bus.o_a_out, bus.o_alu_out}) <= 1) ? 1 : 0, 1);
    end
  end

  // ---------------- directed helpers ----------------
  int          seq_t [8];
  logic [15:0] seq_c [8];

  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge mclk);
      seq_t[i] = int'(bus.o_tstate);
      seq_c[i] = act;
    end
  endtask

  localparam logic [15:0] FETCH0 = 16'h0012;  // pc_out | mar_in
  localparam logic [15:0] FETCH1 = 16'h00C4;  // ram_out | ir_in | pc_inc

  initial begin
    int exp_seq [6];
    bit all_ok;
    i_rst = 1'b1;
    bus.mclk_en = 1'b0;
    bus.i_instr = 8'h00;
    bus.i_zero = 1'b0; bus.i_carry = 1'b0; bus.i_odd = 1'b0;
    repeat (3) @(negedge mclk);
    #1 i_rst = 1'b0; chk_en = 1'b1;

    // Reset state, then 10 edges with the enable low.
    @(negedge mclk);
    chk("reset_tstate", int'(bus.o_tstate), 0);
    chk("reset_ctrl", int'(act), int'(FETCH0));
    repeat (10) @(negedge mclk);
    chk("hold_tstate", int'(bus.o_tstate), 0);
    chk("hold_ctrl", int'(act), int'(FETCH0));

    // ADD: five steps, flags latched only at T4.
    #1 bus.i_instr = 8'h2F; bus.mclk_en = 1'b1;
    collect(5);
    exp_seq = '{0, 1, 2, 3, 4, 0};
    all_ok = 1'b1;
    for (int i = 0; i < 5; i++) if (seq_t[i] != exp_seq[i+1]) all_ok = 1'b0;
    chk("add_tseq", int'(all_ok), 1);
    chk("add_latch_t4", int'(seq_c[3][B_LATCH]), 1);
    chk("add_sub_t4", int'(seq_c[3][B_ALU_SUB]), 0);
    chk("add_latch_t3", int'(seq_c[2][B_LATCH]), 0);

    // SUB: alu_sub and alu_out only at T4.
    #1 bus.i_instr = 8'h3F;
    collect(5);
    chk("sub_t4_sub", int'(seq_c[3][B_ALU_SUB]), 1);
    chk("sub_t4_out", int'(seq_c[3][B_ALU_OUT]), 1);
    chk("sub_t2_out", int'(seq_c[1][B_ALU_OUT]), 0);
    chk("sub_end", seq_t[4], 0);

    // JC taken and not taken.
    #1 bus.i_instr = 8'h7A; bus.i_carry = 1'b1;
    collect(3);
    chk("jc_taken", int'(seq_c[1][B_PC_LOAD]), int'(COND));
    chk("jc_end", seq_t[2], 0);
    #1 bus.i_carry = 1'b0;
    collect(3);
    chk("jc_not_taken", int'(seq_c[1][B_PC_LOAD]), 0);
    chk("jc_nt_end", seq_t[2], 0);

    // HLT sticks, with the enable toggling after the first 20 edges.
    #1 bus.i_instr = 8'hF0;
    collect(2);
    chk("hlt_t2", int'(seq_c[1]), 1);
    all_ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      #1 bus.mclk_en = (i < 20) ? 1'b1 : 1'(($urandom_range(0, 1)));
      @(negedge mclk);
      if (bus.o_tstate != 3'd2 || !bus.o_hlt) all_ok = 1'b0;
    end
    chk("hlt_hold", int'(all_ok), 1);
    #1 i_rst = 1'b1; bus.mclk_en = 1'b0;
    @(negedge mclk);
    chk("hlt_reset_tstate", int'(bus.o_tstate), 0);
    chk("hlt_reset_hlt", int'(bus.o_hlt), 0);

    // Reset in the middle of LDA.
    #1 i_rst = 1'b0; bus.mclk_en = 1'b1; bus.i_instr = 8'h1E;
    collect(3);
    chk("lda_t3", int'(seq_c[2]), int'(16'h0240));  // ram_out | a_in
    #1 i_rst = 1'b1;
    @(negedge mclk);
    chk("lda_reset", int'(bus.o_tstate), 0);
    #1 i_rst = 1'b0;
    @(negedge mclk);
    chk("refetch_tstate", int'(bus.o_tstate), 1);
    chk("refetch_ctrl", int'(act), int'(FETCH1));

    // Random phase. The IR changes only at an instruction boundary, as the
    // fetch would do it.
    for (int i = 0; i < 2000; i++) begin
      #1;
      bus.mclk_en = ($urandom_range(0, 3) != 0);
      bus.i_zero  = 1'($urandom_range(0, 1));
      bus.i_carry = 1'($urandom_range(0, 1));
      bus.i_odd   = 1'($urandom_range(0, 1));
      i_rst       = ($urandom_range(0, 63) == 0);
      if (m_t == 0 && !m_halt) begin
        logic [3:0] op;
        op = 4'($urandom_range(0, 14));
        if ($urandom_range(0, 31) == 0) op = 4'hF;
        bus.i_instr = {op, 4'($urandom_range(0, 15))};
      end
      @(negedge mclk);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
